// File: rtl/tm1638_pkg.sv
// Shared encodings for the TM1638 display sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tm1638_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_ACK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_REQ  = ST_REQ,
        S_ACK  = ST_ACK,
        S_DONE = ST_DONE
    } state_t;

    // Transaction index 0..15 are display writes, 16 is the key read
    localparam logic [4:0] ADDR_KEY_READ = 5'd16;
    localparam int         N_DIGITS      = 8;
    localparam int         N_WRITES      = 16;

endpackage

// File: rtl/tm1638_display_ctrl_hex7seg.sv
// Hex nibble to seven-segment code (gfedcba, active high).
// Latency: combinational.
// Backpressure: none.
// Ports: nib_i - 4-bit hex value; seg_o - segment code, bit 0 = a.
module hex7seg (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (nib_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/tm1638_display_ctrl.sv
// Sequencer feeding a TM1638 driver: 16 display writes then one key read per refresh.
// Latency: strobe 1 cycle after READY seen high; refresh repeats every SCAN_DIV idle clocks.
// Backpressure: waits on DRV_READY before each strobe; holds strobe until READY drops.
// Ports: CLK_IN/RST_IN clock and async active-low reset; EN run enable;
//        HEX_IN/DP_IN/LED_IN display content; KEYS/KEY_VALID key-scan result;
//        DRV_* driver handshake; BUSY high outside IDLE.
module tm1638_display_ctrl
    import tm1638_pkg::*;
#(
    parameter int              CNT_W    = 24,
    parameter logic [CNT_W-1:0] SCAN_DIV = 24'd500000
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic        EN,
    input  logic [31:0] HEX_IN,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  LED_IN,
    output logic [7:0]  KEYS,
    output logic        KEY_VALID,
    output logic [7:0]  DRV_DATA,
    output logic [3:0]  DRV_ADDR,
    output logic        DRV_WRITE,
    output logic        DRV_READ,
    input  logic        DRV_READY,
    input  logic [7:0]  DRV_KEYS,
    output logic        BUSY
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    first_q, first_d;
    logic [4:0]              idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   hex_q, hex_d;
    logic [N_DIGITS-1:0]     dp_q, dp_d;
    logic [N_DIGITS-1:0]     led_q, led_d;
    logic [7:0]              keys_q, keys_d;
    logic                    kv_q, kv_d;
    logic [7:0]              data_q, data_d;
    logic [3:0]              addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic                    rd_q, rd_d;

    // Digit d sits at addresses 2d (segments) and 2d+1 (LED); digit 0 is the
    // most significant nibble, so its bits are picked with ~d (= 7-d).
    logic [2:0] digit;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [7:0] wdata;

    assign digit = idx_q[3:1];
    assign nib   = hex_q[{~digit, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nib_i (nib),
        .seg_o (seg)
    );

    assign wdata = idx_q[0] ? {7'b0, led_q[~digit]} : {dp_q[~digit], seg};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        idx_d   = idx_q;
        hex_d   = hex_q;
        dp_d    = dp_q;
        led_d   = led_q;
        keys_d  = keys_q;
        kv_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;

        case (state_q)
            S_IDLE: begin
                // first_q lets the very first refresh after reset skip the wait
                if (EN) begin
                    if (first_q || (cnt_q == SCAN_DIV - CNT_W'(1))) begin
                        cnt_d   = '0;
                        first_d = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD: begin
                // Shadow copy keeps one refresh coherent even if inputs move
                hex_d   = HEX_IN;
                dp_d    = DP_IN;
                led_d   = LED_IN;
                idx_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (DRV_READY) begin
                    addr_d = idx_q[3:0];
                    if (idx_q == ADDR_KEY_READ) begin
                        rd_d   = 1'b1;
                        data_d = 8'h00;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = wdata;
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // Driver accepted once READY drops; release the strobe right away
                if (!DRV_READY) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (DRV_READY) begin
                    if (idx_q == ADDR_KEY_READ) begin
                        keys_d  = DRV_KEYS;
                        kv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b1;
            idx_q   <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            led_q   <= '0;
            keys_q  <= '0;
            kv_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            led_q   <= led_d;
            keys_q  <= keys_d;
            kv_q    <= kv_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign KEYS      = keys_q;
    assign KEY_VALID = kv_q;
    assign DRV_DATA  = data_q;
    assign DRV_ADDR  = addr_q;
    assign DRV_WRITE = wr_q;
    assign DRV_READ  = rd_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tm1638_display_ctrl.sv
// Bench for tm1638_display_ctrl: driver model plus transaction scoreboard.
// Latency: n/a.
// Backpressure: driver model drops READY for 20 cycles per accepted strobe.
module tb_tm1638_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] hex = 32'h0;
    logic [7:0]  dp = 8'h0;
    logic [7:0]  led = 8'h0;
    logic [7:0]  keys;
    logic        key_valid;
    logic [7:0]  drv_data;
    logic [3:0]  drv_addr;
    logic        drv_write;
    logic        drv_read;
    logic        drv_ready;
    logic [7:0]  drv_keys = 8'h00;
    logic        busy;

    logic        hold_low = 1'b1;
    logic        mdl_rdy = 1'b1;
    int          mdl_busy = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_kv = 1'b0;
    int          nstrobe = 0;
    int          stuck = 0;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] keys;
    } txn_t;

    txn_t       sb[$];
    logic [7:0] key_q[$];

    assign drv_ready = mdl_rdy & ~hold_low;

    always #5 clk = ~clk;

    tm1638_display_ctrl #(.CNT_W(24), .SCAN_DIV(24'd8)) dut (
        .CLK_IN    (clk),
        .RST_IN    (rst_n),
        .EN        (en),
        .HEX_IN    (hex),
        .DP_IN     (dp),
        .LED_IN    (led),
        .KEYS      (keys),
        .KEY_VALID (key_valid),
        .DRV_DATA  (drv_data),
        .DRV_ADDR  (drv_addr),
        .DRV_WRITE (drv_write),
        .DRV_READ  (drv_read),
        .DRV_READY (drv_ready),
        .DRV_KEYS  (drv_keys),
        .BUSY      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    // Expected transactions of one full refresh captured from these inputs
    task automatic push_cycle(input logic [31:0] hx, input logic [7:0] dpv,
                              input logic [7:0] ldv, input logic [7:0] kv);
        txn_t e;
        for (int i = 0; i < 16; i++) begin
            e.rd   = 1'b0;
            e.addr = i[3:0];
            e.keys = 8'h00;
            if (i % 2 == 0)
                e.data = {dpv[7 - i/2], seg7(hx[31 - 4*(i/2) -: 4])};
            else
                e.data = {7'b0, ldv[7 - i/2]};
            sb.push_back(e);
        end
        e.rd = 1'b1; e.addr = 4'h0; e.data = 8'h00; e.keys = kv;
        sb.push_back(e);
        key_q.push_back(kv);
    endtask

    // Driver model and monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_rdy     = 1'b1;
            mdl_busy    = 0;
            prev_strobe = 1'b0;
            prev_kv     = 1'b0;
        end else begin
            logic strobe;
            txn_t e;
            strobe = drv_write | drv_read;
            if (strobe && !drv_ready) stuck++;
            if (strobe && !prev_strobe) begin
                nstrobe++;
                chk("excl", {31'b0, drv_write & drv_read}, 0);
                chk("sb_nonempty", {31'b0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.rd) begin
                        chk("rd_strobe", {drv_read, drv_write}, 2'b10);
                        drv_keys = e.keys;
                    end else begin
                        chk("wr_txn", {drv_read, drv_write, drv_addr, drv_data},
                            {1'b0, 1'b1, e.addr, e.data});
                    end
                end
            end
            if (mdl_busy > 0) begin
                mdl_busy--;
                if (mdl_busy == 0) mdl_rdy = 1'b1;
            end else if (strobe && !prev_strobe && mdl_rdy) begin
                mdl_rdy  = 1'b0;
                mdl_busy = 20;
            end
            prev_strobe = strobe;
            if (key_valid) begin
                chk("kv_single", {31'b0, prev_kv}, 0);
                chk("key_q_nonempty", {31'b0, key_q.size() != 0}, 1);
                if (key_q.size() != 0) chk("keys", keys, key_q.pop_front());
            end
            prev_kv = key_valid;
        end
    end

    task automatic wait_kv(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_valid && n < 3000);
        chk(tag, {31'b0, key_valid}, 1);
    endtask

    task automatic wait_wr(input string tag, input logic [3:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(drv_write && drv_addr == a) && n < 3000);
        chk(tag, {31'b0, drv_write && drv_addr == a}, 1);
    endtask

    initial begin
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outs", {keys, key_valid, drv_data, drv_addr, drv_write, drv_read, busy}, 0);

        // Cycle 1 with READY held low for 100 cycles
        hex = 32'h0123ABCD; dp = 8'h01; led = 8'h80;
        push_cycle(32'h0123ABCD, 8'h01, 8'h80, 8'hA5);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (100) @(negedge clk);
        chk("no_strobe_while_low", nstrobe, 0);
        chk("busy_waiting", {31'b0, busy}, 1);
        chk("wr_before_ready", {31'b0, drv_write}, 0);
        hold_low = 1'b0;
        @(posedge clk); #1;
        chk("wr_1cyc_after_ready", {31'b0, drv_write}, 1);

        wait_kv("kv_c1");
        // Inputs for the next two refreshes, then measure the idle gap
        hex = 32'h11111111; dp = 8'h00; led = 8'h00;
        push_cycle(32'h11111111, 8'h00, 8'h00, 8'h3C);
        push_cycle(32'h22222222, 8'h00, 8'h00, 8'hC3);
        n = 0;
        while (!busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("idle_gap", n, 8);

        // Mid-refresh change must not leak into the current refresh
        wait_wr("wr5_c2", 4'd5);
        hex = 32'h22222222;
        wait_kv("kv_c2");

        wait_wr("wr0_c3", 4'd0);
        hex = 32'hDEADBEEF; dp = 8'hA5; led = 8'h3C;
        push_cycle(32'hDEADBEEF, 8'hA5, 8'h3C, 8'h5A);
        wait_kv("kv_c3");

        // EN dropped mid-refresh: refresh completes, then stays idle
        wait_wr("wr3_c4", 4'd3);
        en  = 1'b0;
        hex = 32'h0;
        wait_kv("kv_c4");
        chk("sb_drain_c4", sb.size(), 0);
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("en_off_idle", n, 0);

        hex = 32'h13579BDF; dp = 8'h0F; led = 8'hF0;
        push_cycle(32'h13579BDF, 8'h0F, 8'hF0, 8'h77);
        en = 1'b1;

        // Reset pulse while a write is held in ACK
        wait_wr("wr2_c5", 4'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_async", {31'b0, drv_write}, 0);
        chk("rst_outs", {keys, key_valid, drv_data, drv_addr, drv_write, drv_read, busy}, 0);
        repeat (3) @(negedge clk);
        sb.delete();
        key_q.delete();
        hex = 32'hFEDCBA98; dp = 8'h80; led = 8'h01;
        push_cycle(32'hFEDCBA98, 8'h80, 8'h01, 8'h99);
        #2 rst_n = 1'b1;
        wait_kv("kv_c6");
        chk("sb_drain_c6", sb.size(), 0);
        chk("strobe_vs_ready", stuck, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tm1638_display_ctrl.md
Name: tm1638_display_ctrl

Overview:
- Upstream sequencer for the TM1638 serial driver; it drives the driver's DATA_IN/ADDR/WRITE/READ inputs and consumes its READY/DATA_OUT outputs.
- Periodically refreshes all 8 seven-segment digits and 8 discrete LEDs from parallel inputs.
- After each refresh it performs one key-scan read and presents the 8 key bits to the rest of the design.
- Converts a 32-bit hex value to segment codes internally, so user logic never deals with TM1638 addressing.

Parameters:
- SCAN_DIV, 24'd500000, idle clocks between the end of one refresh/scan cycle and the start of the next; legal range 1..2^24-1.
- CNT_W, 24, width of the idle counter; SCAN_DIV must fit in it.

Ports:
- CLK_IN  input  1  system clock, same clock as the driver; all logic on posedge.
- RST_IN  input  1  asynchronous active-low reset.
- EN  input  1  1 = run refresh cycles; 0 = finish the current transaction, then stay in IDLE.
- HEX_IN  input  32  displayed value; HEX_IN[31:28] goes to digit 0 (leftmost, addr 0), HEX_IN[3:0] to digit 7 (addr 14).
- DP_IN  input  8  decimal points; DP_IN[7] goes to digit 0, DP_IN[0] to digit 7.
- LED_IN  input  8  discrete LEDs; LED_IN[7] goes to addr 1, LED_IN[0] to addr 15.
- KEYS  output  8  last key-scan result (driver DATA_OUT copy).
- KEY_VALID  output  1  1-cycle pulse when KEYS is updated.
- DRV_DATA  output  8  to driver DATA_IN.
- DRV_ADDR  output  4  to driver ADDR.
- DRV_WRITE  output  1  to driver WRITE.
- DRV_READ  output  1  to driver READ.
- DRV_READY  input  1  from driver READY (1 = driver idle).
- DRV_KEYS  input  8  from driver DATA_OUT.
- BUSY  output  1  1 whenever state != IDLE.

Behaviour:
- Reset: all outputs are 0 (KEYS=8'h00, KEY_VALID=0, DRV_*=0, BUSY=0); state=IDLE; idle counter=0; index=0. The first cycle starts immediately once EN=1.
- States: IDLE, LOAD, REQ, ACK, DONE.
- IDLE:
  - Counter counts up while EN=1.
  - When counter reaches SCAN_DIV-1 (or is 0 after reset), clear it and go to LOAD.
  - With EN=0 the counter holds.
- LOAD (1 cycle):
  - Snapshot HEX_IN, DP_IN and LED_IN into shadow registers, so the refresh is coherent.
  - Set index=0 and go to REQ.
- Index sequence: 0..15 are writes, with DRV_ADDR=index.
  - Even index i gives DRV_DATA = {dp, seg[6:0]} for digit i/2.
  - Odd index gives DRV_DATA = {7'b0, led bit}.
  - Index 16 is the key read.
- REQ:
  - If DRV_READY=0 (driver still in its init or busy), hold with DRV_WRITE=DRV_READ=0.
  - Otherwise assert DRV_WRITE (index<16) or DRV_READ (index=16), with DRV_ADDR/DRV_DATA valid, then go to ACK.
- ACK:
  - Hold the strobe, address and data stable until DRV_READY=0.
  - On that cycle drop the strobe to 0 and go to DONE.
  - The strobe must never be high while READY is low for more than 1 cycle.
- DONE:
  - Wait for DRV_READY=1.
  - If index<16: index+1 and go to REQ.
  - If index=16: KEYS<=DRV_KEYS, KEY_VALID=1 for that cycle, then IDLE.
- DRV_WRITE and DRV_READ are mutually exclusive, and never both 1.
- Segment encoding is gfedcba with dp on bit 7: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- EN falling mid-cycle: the current cycle (through the key read) completes, then the block stays in IDLE.
- Input changes during a cycle have no effect until the next LOAD.
- Reset assertion mid-transaction: immediate return to reset values; the strobe drops asynchronously.
- SCAN_DIV=1: back-to-back cycles with 1 IDLE cycle between them.

Decomposition:
- Package tm1638_pkg holds:
  - state encoding (3-bit localparams);
  - ADDR_KEY_READ index constant 16;
  - N_DIGITS=8 and N_WRITES=16.
- One sub-module, hex7seg: 4-bit nibble in, 7-bit segment code out, purely combinational. It is instantiated once and muxed by index.

Test Plan:
- Reset then EN=1, HEX_IN=32'h0123ABCD, DP_IN=8'h01, LED_IN=8'h80, with a driver model (READY falls 1 cycle after strobe, rises after 20 cycles) -> writes in order: (0,3F) (1,01) (2,06) (3,00) (4,5B) … (14,DE) (15,00), then one read.
- Driver model returns DRV_KEYS=8'hA5 on the read -> KEYS=8'hA5 with a single-cycle KEY_VALID, BUSY falls the following cycle, next LOAD after SCAN_DIV=8 idle cycles.
- DRV_READY held 0 for 100 cycles after reset -> no strobe asserted; first DRV_WRITE appears 1 cycle after READY rises.
- HEX_IN changed from 32'h11111111 to 32'h22222222 at write index 5 -> all digits in that cycle carry 06; the next cycle carries 5B.
- EN dropped at index 3 -> indices 4..16 still issued, then IDLE with no new LOAD for 1000 cycles; EN=1 restarts.
- RST_IN pulsed low while DRV_WRITE=1 in ACK -> DRV_WRITE=0 immediately, all outputs at reset values, a clean full cycle after release.
